pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline stage register for inter-stage boundaries (FD/DX/XM/MW).
//  Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and a bubble value.
//  Stages can stall and squash without a combinational ready path back through the stage.
//  Control and data fields are concatenated into one DATA_W payload by the instantiating stage.
// PARAMETERS
//  DATA_W   16     payload width in bits, >=1
//  NOP_VAL  '0     payload driven on out_data whenever out_valid=0 (bubble/NOP encoding)
//  CNT_W    16     perf counter width; used only with PIPE_STAGE_PERF_EN
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  flush        in   1       synchronous squash of all held entries
//  in_valid     in   1       upstream payload valid
//  in_ready     out  1       stage can accept; registered
//  in_data      in   DATA_W  upstream payload
//  out_valid    out  1       downstream payload valid
//  out_ready    in   1       downstream accepts
//  out_data     out  DATA_W  payload; NOP_VAL when out_valid=0
//  occupancy    out  2       entries held: 0, 1 or 2
//  stall_cnt    out  CNT_W   only with PIPE_STAGE_PERF_EN
//  squash_cnt   out  CNT_W   only with PIPE_STAGE_PERF_EN
// BEHAVIOUR
//  - Reset (rst=0, async): state EMPTY, out_valid=0, out_data=NOP_VAL, in_ready=1, occupancy=0, counters 0.
//  - Upstream transfer: in_valid&in_ready at posedge. Downstream transfer: out_valid&out_ready at posedge.
//  - States and transitions, with flush=0:
//      EMPTY: in xfer -> FULL, main<=in_data; else stay.
//      FULL:  out_ready&in_valid -> FULL, main<=in_data.
//             out_ready&!in_valid -> EMPTY.
//             !out_ready&in_valid -> SKID, skid<=in_data.
//             neither -> hold.
//      SKID:  in_ready=0; out_ready -> FULL, main<=skid; else hold both.
//  - in_ready is a flop equal to (next_state!=SKID). No comb path out_ready->in_ready.
//  - Latency: 1 cycle in_data->out_data when unstalled. Full throughput: 1 xfer/cycle.
//  - Ordering strictly FIFO; no payload is dropped or duplicated except by flush.
//  - out_data: main when out_valid=1, else NOP_VAL (muxed, never X).
//  - flush=1 overrides all: next state EMPTY, main/skid<=NOP_VAL, in_ready<=1.
//    A same-cycle in xfer is consumed and discarded. A same-cycle out xfer still completes.
//  - Reset asserted mid-transfer: entries lost; state as reset.
//    Inputs ignored until the first edge after rst deasserts.
//  - occupancy = 0/1/2 for EMPTY/FULL/SKID, combinational from the state register.
// CONFIGURATION
//  PIPE_STAGE_PERF_EN defined: adds stall_cnt and squash_cnt.
//    stall_cnt: +1 each cycle out_valid&!out_ready.
//    squash_cnt: +occupancy each flush cycle.
//    Both saturate at 2^CNT_W-1; reset only by rst.
//  Undefined: both ports and all counter logic absent; core behaviour identical.
// STRUCTURE
//  pipe_pkg:
//    typedef enum logic[1:0] pipe_state_t {PS_EMPTY=0, PS_FULL=1, PS_SKID=2}.
//    localparam PIPE_OCC_MAX=2.
//  Sub-module pipe_sat_cnt (#(CNT_W)): async active-low reset, inc amount 0..2, saturating.
//    Instantiated twice under PIPE_STAGE_PERF_EN.
// TESTING
//  1. Stream 0x0001..0x0008 on consecutive cycles, out_ready=1
//     -> each word out 1 cycle later; out_valid 8 cycles; in_ready stays 1.
//  2. Send 0xAAAA, 0xBBBB, out_ready=0
//     -> occupancy 2, in_ready=0; raise out_ready -> 0xAAAA then 0xBBBB, no loss.
//  3. Occupancy 2 and flush=1 with in_valid=1 (0xCCCC)
//     -> next cycle out_valid=0, out_data=NOP_VAL, in_ready=1, 0xCCCC never appears.
//  4. rst low mid-stream with occupancy 1
//     -> out_valid=0, out_data=NOP_VAL immediately (before clk edge); resumes on next xfer.
//  5. PERF_EN, CNT_W=4: hold out_ready=0 for 20 cycles with valid data
//     -> stall_cnt=15 (saturated); flush at occupancy 2 -> squash_cnt=2.
//  6. Random valid/ready/flush over 10k cycles vs queue model
//     -> output order matches, no X on out_data, in_ready==(occupancy<2).

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// pipe_pkg: shared types and constants for the elastic pipeline stage.
//   pipe_state_t : stage state (EMPTY / FULL / SKID); the encoding equals
//                  the number of entries held.
//   PIPE_OCC_MAX : maximum number of entries one stage can hold.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  localparam int unsigned PIPE_OCC_MAX = 2;

endpackage

// File: rtl/pipe_stage_elastic_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with a 0..2 increment per cycle.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (clears the count)
//   inc_i  : amount added this cycle (0, 1 or 2)
//   cnt_o  : current count; holds at 2^CNT_W-1 once reached
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   sum;

  // One extra bit catches the wrap; cnt_q + 2 never exceeds 2^(CNT_W+1)-1.
  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline stage register with valid/ready
// handshake, 2-entry skid buffer, synchronous flush and bubble value.
// in_ready is registered, so there is no combinational path from
// out_ready back to in_ready.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   flush      : synchronous squash of all held entries
//   in_valid   : upstream payload valid
//   in_ready   : stage can accept (registered)
//   in_data    : upstream payload
//   out_valid  : downstream payload valid
//   out_ready  : downstream accepts
//   out_data   : payload, NOP_VAL whenever out_valid=0
//   occupancy  : entries held (0, 1, 2)
//   stall_cnt  : cycles with out_valid & !out_ready (PIPE_STAGE_PERF_EN only)
//   squash_cnt : entries discarded by flush (PIPE_STAGE_PERF_EN only)
// Configuration macro: PIPE_STAGE_PERF_EN enables the saturating perf counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W  = 16,
  parameter logic [DATA_W-1:0]    NOP_VAL = '0,
  parameter int unsigned          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
`endif
);

  pipe_state_t       state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              out_valid_q;

  // Outputs are registered alongside the state: in_ready_q tracks
  // (next state != SKID), out_valid_q tracks (next state != EMPTY).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PS_EMPTY;
      main_q      <= NOP_VAL;
      skid_q      <= NOP_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= PS_EMPTY;
      main_q      <= NOP_VAL;
      skid_q      <= NOP_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_valid) begin
            state_q     <= PS_FULL;
            main_q      <= in_data;
            out_valid_q <= 1'b1;
          end
        end
        PS_FULL: begin
          if (out_ready && in_valid) begin
            main_q <= in_data;
          end else if (out_ready) begin
            state_q     <= PS_EMPTY;
            out_valid_q <= 1'b0;
          end else if (in_valid) begin
            state_q    <= PS_SKID;
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
          end
        end
        PS_SKID: begin
          if (out_ready) begin
            state_q    <= PS_FULL;
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= PS_EMPTY;
          main_q      <= NOP_VAL;
          skid_q      <= NOP_VAL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      PS_EMPTY: occupancy = 2'd0;
      PS_FULL:  occupancy = 2'd1;
      PS_SKID:  occupancy = 2'(PIPE_OCC_MAX);
      default:  occupancy = 2'd0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // main_q keeps stale data after a drain, so the bubble value is muxed in.
  assign out_data  = out_valid_q ? main_q : NOP_VAL;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  ({1'b0, out_valid_q & ~out_ready}),
    .cnt_o  (stall_cnt)
  );

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_squash_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (flush ? occupancy : 2'd0),
    .cnt_o  (squash_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  localparam int unsigned DW  = 16;
  localparam logic [15:0] NOP = 16'h5A5A;
  localparam int unsigned CW  = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] squash_cnt;
`endif

  pipe_stage_elastic #(
    .DATA_W  (DW),
    .NOP_VAL (NOP),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .squash_cnt (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the stage is a FIFO of capacity 2.
  logic [DW-1:0] q[$];
  int unsigned   stall_m  = 0;
  int unsigned   squash_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on each falling edge compare outputs with the model, then
  // advance the model by what the next rising edge will do.
  always @(negedge clk) begin
    int unsigned sz;
    logic [DW-1:0] exp_d;
    if (!rst) begin
      q.delete();
      stall_m  = 0;
      squash_m = 0;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
      chk("rst_out_data", {16'b0, out_data}, {16'b0, NOP});
    end else begin
      sz = q.size();
      chk("out_valid", {31'b0, out_valid}, {31'b0, sz > 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, sz < 2});
      chk("occupancy", {30'b0, occupancy}, sz);
      chk("out_data_known", {31'b0, $isunknown(out_data)}, 32'd0);
      if (sz == 0) chk("out_data_nop", {16'b0, out_data}, {16'b0, NOP});
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", {28'b0, stall_cnt}, stall_m);
      chk("squash_cnt", {28'b0, squash_cnt}, squash_m);
      if (sz > 0 && !out_ready) stall_m = (stall_m < CNT_MAX) ? stall_m + 1 : CNT_MAX;
      if (flush) squash_m = (squash_m + sz < CNT_MAX) ? squash_m + sz : CNT_MAX;
`endif
      if (sz > 0 && out_ready) begin
        exp_d = q.pop_front();
        chk("out_xfer_data", {16'b0, out_data}, {16'b0, exp_d});
      end
      if (flush) q.delete();
      else if (in_valid && sz < 2) q.push_back(in_data);
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Fill to skid with downstream stalled, then drain in order.
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("skid_occupancy", {30'b0, occupancy}, 32'd2);
    chk("skid_in_ready", {31'b0, in_ready}, 32'd0);
    chk("skid_head", {16'b0, out_data}, 32'h0000AAAA);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Long stall to saturate the stall counter.
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    repeat (20) drive(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_saturated", {28'b0, stall_cnt}, CNT_MAX);
`endif

    // Flush at occupancy 2 with a simultaneous upstream transfer.
    drive(1'b1, 16'h5678, 1'b0, 1'b0);
    drive(1'b1, 16'hCCCC, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_out_data", {16'b0, out_data}, {16'b0, NOP});
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("squash_after_flush", {28'b0, squash_cnt}, 32'd2);
`endif
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with one entry held.
    drive(1'b1, 16'h3333, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_out_data", {16'b0, out_data}, {16'b0, NOP});
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, 16'h4444, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
